// File: rtl/plic_cond_pkg.sv
// Shared constants and helpers for the PLIC interrupt conditioner.
package plic_cond_pkg;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned FILTER_W_DEF    = 4;

  typedef logic [FILTER_W_DEF-1:0] filt_cnt_t;

  // Width of a down-counter that must hold the value sync_stages.
  function automatic int unsigned holdoff_w(input int unsigned sync_stages);
    return (sync_stages < 2) ? 1 : $clog2(sync_stages + 1);
  endfunction

endpackage

// File: rtl/plic_irq_filter.sv
// One source's stability filter and sticky glitch flag.
// Filter and glitch logic exist only with PLIC_IRQ_FILTER_EN; otherwise the source passes straight through.
module plic_irq_filter
  import plic_cond_pkg::*;
#(
  parameter int unsigned FILTER_W = FILTER_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                norm_i,
  input  logic [FILTER_W-1:0] len_i,
  input  logic                holdoff_i,
  input  logic                irq_en_i,
  input  logic                glitch_clr_i,
  output logic                irq_o,
  output logic                glitch_o
);

  logic irq_q, irq_d;

`ifdef PLIC_IRQ_FILTER_EN
  logic                filt_q, filt_d;
  logic [FILTER_W-1:0] cnt_q, cnt_d;
  logic                glitch_q, glitch_d;

  // A change is accepted once it has been seen for len_i+1 consecutive samples.
  always_comb begin
    filt_d   = filt_q;
    cnt_d    = '0;
    glitch_d = glitch_q & ~glitch_clr_i;
    if (holdoff_i) begin
      filt_d   = norm_i;
      glitch_d = glitch_q;
    end else if (norm_i != filt_q) begin
      if (cnt_q >= len_i) begin
        filt_d = norm_i;
      end else begin
        cnt_d = cnt_q + FILTER_W'(1);
      end
    end else if (cnt_q != '0) begin
      glitch_d = 1'b1;
    end
    irq_d = irq_en_i & filt_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q   <= 1'b0;
      cnt_q    <= '0;
      glitch_q <= 1'b0;
    end else begin
      filt_q   <= filt_d;
      cnt_q    <= cnt_d;
      glitch_q <= glitch_d;
    end
  end

  assign glitch_o = glitch_q;
`else
  logic unused_c;

  always_comb begin
    irq_d = irq_en_i & norm_i;
  end

  assign unused_c = ^{len_i, holdoff_i, glitch_clr_i};
  assign glitch_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;

endmodule

// File: rtl/plic_irq_conditioner.sv
// Conditions raw device interrupt lines into clean clk_i-synchronous sources for plic_top.
// Optional deglitch filter and glitch status are built when PLIC_IRQ_FILTER_EN is defined.
module plic_irq_conditioner
  import plic_cond_pkg::*;
#(
  parameter int unsigned N_SOURCE    = 30,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned FILTER_W    = FILTER_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [N_SOURCE-1:0] irq_raw_i,
  input  logic [N_SOURCE-1:0] polarity_i,
  input  logic [FILTER_W-1:0] filter_len_i,
  input  logic                glitch_clr_i,
  output logic [N_SOURCE-1:0] irq_o,
  output logic [N_SOURCE-1:0] glitch_o
);

  localparam int unsigned HOLD_W = holdoff_w(SYNC_STAGES);

  logic [N_SOURCE-1:0] sync_q [SYNC_STAGES];
  logic [N_SOURCE-1:0] sync_d [SYNC_STAGES];
  logic [N_SOURCE-1:0] norm_c;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                hold_q, hold_d;

  always_comb begin
    sync_d[0] = irq_raw_i;
    for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_d[s];
      end
    end
  end

  // Polarity applied after the chain so only synchronised values reach logic.
  assign norm_c = sync_q[SYNC_STAGES-1] ^ polarity_i;

  // The hold flag lags the counter by one cycle, so the filter tracks norm until the
  // reset zeros have fully drained from the chain.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (hold_cnt_q != '0) begin
      hold_cnt_d = hold_cnt_q - HOLD_W'(1);
    end
    hold_d = (hold_cnt_q != '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_cnt_q <= HOLD_W'(SYNC_STAGES);
      hold_q     <= 1'b1;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      hold_q     <= hold_d;
    end
  end

  for (genvar i = 0; i < N_SOURCE; i++) begin : g_src
    plic_irq_filter #(
      .FILTER_W (FILTER_W)
    ) u_filter (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .norm_i       (norm_c[i]),
      .len_i        (filter_len_i),
      .holdoff_i    (hold_q),
      .irq_en_i     (~hold_d),
      .glitch_clr_i (glitch_clr_i),
      .irq_o        (irq_o[i]),
      .glitch_o     (glitch_o[i])
    );
  end

endmodule

// File: tb/tb_plic_irq_conditioner.sv
// Directed self-checking bench for plic_irq_conditioner; expectations follow PLIC_IRQ_FILTER_EN.
module tb_plic_irq_conditioner;

  localparam int unsigned NS = 30;
  localparam int unsigned SS = 2;
  localparam int unsigned FW = 4;
`ifdef PLIC_IRQ_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [NS-1:0] irq_raw_i;
  logic [NS-1:0] polarity_i;
  logic [FW-1:0] filter_len_i;
  logic          glitch_clr_i;
  logic [NS-1:0] irq_o;
  logic [NS-1:0] glitch_o;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  plic_irq_conditioner #(
    .N_SOURCE    (NS),
    .SYNC_STAGES (SS),
    .FILTER_W    (FW)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .irq_raw_i    (irq_raw_i),
    .polarity_i   (polarity_i),
    .filter_len_i (filter_len_i),
    .glitch_clr_i (glitch_clr_i),
    .irq_o        (irq_o),
    .glitch_o     (glitch_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  function automatic int unsigned lat(input int unsigned l);
    return FILT_EN ? SS + l + 1 : SS + 1;
  endfunction

  initial begin
    rst_ni       = 1'b0;
    irq_raw_i    = '1;
    polarity_i   = '1;
    filter_len_i = FW'(3);
    glitch_clr_i = 1'b0;

    // 1: idle active-low sources must leave reset deasserted
    tick(2);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_glitch", 32'(glitch_o), 32'd0);
    rst_ni = 1'b1;
    for (int unsigned k = 1; k <= 10; k++) begin
      tick(1);
      check("t1_irq", 32'(irq_o), 32'd0);
    end
    check("t1_glitch", 32'(glitch_o), 32'd0);

    // switch to active-high idle sources under reset
    rst_ni     = 1'b0;
    polarity_i = '0;
    irq_raw_i  = '0;
    tick(2);
    rst_ni = 1'b1;
    tick(5);
    check("reinit_irq", 32'(irq_o), 32'd0);

    // 2: L=3 assert and deassert latency
    filter_len_i = FW'(3);
    irq_raw_i[5] = 1'b1;
    for (int unsigned k = 1; k <= lat(3); k++) begin
      tick(1);
      check("t2_rise", 32'(irq_o[5]), 32'(k == lat(3)));
    end
    tick(2);
    irq_raw_i[5] = 1'b0;
    for (int unsigned k = 1; k <= lat(3); k++) begin
      tick(1);
      check("t2_fall", 32'(irq_o[5]), 32'(k != lat(3)));
    end
    check("t2_glitch", 32'(glitch_o), 32'd0);

    // 3: 2-cycle pulse rejected at L=3, then cleared
    irq_raw_i[7] = 1'b1;
    for (int unsigned k = 1; k <= 8; k++) begin
      tick(1);
      if (k == 2) irq_raw_i[7] = 1'b0;
      check("t3_irq", 32'(irq_o[7]), 32'(!FILT_EN && (k == 3 || k == 4)));
      check("t3_glitch", 32'(glitch_o[7]), 32'(FILT_EN && k >= 5));
    end
    glitch_clr_i = 1'b1;
    tick(1);
    glitch_clr_i = 1'b0;
    check("t3_clr", 32'(glitch_o), 32'd0);

    // 4: L=0 single-cycle pulse passes with 3-cycle latency
    filter_len_i = FW'(0);
    irq_raw_i[0] = 1'b1;
    for (int unsigned k = 1; k <= 5; k++) begin
      tick(1);
      if (k == 1) irq_raw_i[0] = 1'b0;
      check("t4_irq", 32'(irq_o[0]), 32'(k == 3));
    end
    check("t4_glitch", 32'(glitch_o), 32'd0);

    // 5: lowering L mid-count accepts the change next cycle
    filter_len_i = FW'(15);
    irq_raw_i[3] = 1'b1;
    tick(10);
    check("t5_pending", 32'(irq_o[3]), 32'(!FILT_EN));
    filter_len_i = FW'(4);
    tick(1);
    check("t5_accept", 32'(irq_o[3]), 32'd1);

    // 5b: glitch set in the same cycle as clear wins
    irq_raw_i[9] = 1'b1;
    tick(1);
    irq_raw_i[9] = 1'b0;
    tick(2);
    glitch_clr_i = 1'b1;
    tick(1);
    glitch_clr_i = 1'b0;
    check("t5_set_wins", 32'(glitch_o[9]), 32'(FILT_EN));
    check("t5_irq9", 32'(irq_o[9]), 32'd0);
    glitch_clr_i = 1'b1;
    tick(1);
    glitch_clr_i = 1'b0;
    check("t5_clr", 32'(glitch_o), 32'd0);

    // 6: reset mid-count clears outputs at once; release restarts the pipeline
    filter_len_i  = FW'(3);
    irq_raw_i[12] = 1'b1;
    tick(4);
    check("t6_pre", 32'(irq_o[12]), 32'(!FILT_EN));
    rst_ni = 1'b0;
    #1;
    check("t6_async_irq", 32'(irq_o), 32'd0);
    check("t6_async_glitch", 32'(glitch_o), 32'd0);
    filter_len_i = FW'(0);
    tick(2);
    rst_ni = 1'b1;
    for (int unsigned k = 1; k <= lat(0); k++) begin
      tick(1);
      check("t6_irq12", 32'(irq_o[12]), 32'(k == lat(0)));
      check("t6_irq3", 32'(irq_o[3]), 32'(k == lat(0)));
    end
    tick(3);
    check("t6_hold", 32'(irq_o), 32'((NS'(1) << 12) | (NS'(1) << 3)));
    check("t6_glitch", 32'(glitch_o), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
